// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and fetch-unit defaults.
// Used by fetch, decode and pipeline control.
package y86_pkg;
    localparam int           Y86_ADDR_W   = 64;
    localparam logic [63:0]  Y86_RESET_PC = 64'h0;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    function automatic logic icode_invalid(input logic [3:0] icode);
        return icode >= 4'hC;
    endfunction
endpackage

// File: rtl/y86_ras.sv
// Return-address stack: circular buffer, oldest entry overwritten on push when full.
// Latency: top_dat combinational, push/pop/flush take effect on the next edge.
// Backpressure: none; caller gates push/pop/flush, pop on empty is ignored.
module y86_ras #(
    parameter int  ADDR_W    = 64,
    parameter int  RAS_DEPTH = 8,
    localparam int PW        = $clog2(RAS_DEPTH),
    localparam int CW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_dat,
    output logic [ADDR_W-1:0] top_dat,
    output logic [CW-1:0]     count,
    output logic              empty
);
    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     eff_ptr;
    logic [PW-1:0]     top_idx;
    logic [CW-1:0]     eff_count;
    logic              full;
    logic              do_pop;

    // A flush is applied ahead of the same cycle's push/pop, so empty/top see the flushed view.
    assign eff_ptr   = flush ? '0 : ptr;
    assign eff_count = flush ? '0 : count;
    assign top_idx   = eff_ptr - PW'(1);
    assign top_dat   = mem[top_idx];
    assign empty     = (eff_count == '0);
    assign full      = (eff_count == CW'(RAS_DEPTH));
    assign do_pop    = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr   <= eff_ptr + PW'(1);
            count <= full ? eff_count : eff_count + CW'(1);
        end else if (do_pop) begin
            ptr   <= top_idx;
            count <= eff_count - CW'(1);
        end else begin
            ptr   <= eff_ptr;
            count <= eff_count;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[eff_ptr] <= push_dat;
    end
endmodule

// File: rtl/y86_fetch_pc_unit.sv
// Fetch-PC generator: predicted PC register, RAS-based return prediction, redirect mux.
// Latency: f_pc combinational from redirects; pred_pc updates one edge after a fetch.
// Backpressure: f_stall freezes all state; ret_pending asks control to bubble fetch.
module y86_fetch_pc_unit
    import y86_pkg::*;
#(
    parameter int                ADDR_W    = Y86_ADDR_W,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(Y86_RESET_PC),
    parameter bit                RAS_EN    = 1'b1,
    localparam int               CW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_stall,
    input  logic              f_valid,
    input  logic [3:0]        f_icode,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic              m_mispredict,
    input  logic [ADDR_W-1:0] m_valA,
    input  logic              w_ret,
    input  logic [ADDR_W-1:0] w_valM,
    output logic [ADDR_W-1:0] f_pc,
    output logic [ADDR_W-1:0] pred_pc,
    output logic              ras_hit,
    output logic              ret_pending,
    output logic              halted,
    output logic [CW-1:0]     ras_count
);
    logic              upd;
    logic              is_call;
    logic              is_ret;
    logic              is_stop;
    logic              ras_flush;
    logic              ras_empty;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] next_pc;

    assign f_pc    = m_mispredict ? m_valA : (w_ret ? w_valM : pred_pc);
    assign upd     = f_valid & ~f_stall & ~halted & ~(ret_pending & ~w_ret);
    assign is_call = (f_icode == I_CALL);
    assign is_ret  = (f_icode == I_RET);
    assign is_stop = (f_icode == I_HALT) | icode_invalid(f_icode);

    // w_ret with no ret outstanding means the RAS predicted wrongly: discard it.
    assign ras_flush = w_ret & ~ret_pending & ~f_stall;
    assign ras_hit   = upd & is_ret & RAS_EN & ~ras_empty;

    y86_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (reset),
        .flush    (ras_flush),
        .push     (upd & is_call),
        .pop      (ras_hit),
        .push_dat (f_valP),
        .top_dat  (ras_top),
        .count    (ras_count),
        .empty    (ras_empty)
    );

    always_comb begin
        next_pc = f_valP;
        if (is_call || f_icode == I_JXX) next_pc = f_valC;
        else if (ras_hit)                next_pc = ras_top;
        else if (is_stop)                next_pc = f_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_pc     <= RESET_PC;
            ret_pending <= 1'b0;
            halted      <= 1'b0;
        end else if (!f_stall) begin
            if (w_ret) ret_pending <= 1'b0;
            if (upd) begin
                pred_pc <= next_pc;
                if (is_ret && !ras_hit) ret_pending <= 1'b1;
                if (is_stop)            halted      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_y86_fetch_pc_unit.sv
// Directed bench for y86_fetch_pc_unit: RAS_EN=1 and RAS_EN=0 instances on shared inputs,
// expected outputs queued per cycle and checked by a negedge monitor.
module tb_y86_fetch_pc_unit;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_stall, f_valid, m_mispredict, w_ret;
    logic [3:0]  f_icode;
    logic [63:0] f_valC, f_valP, m_valA, w_valM;

    logic [63:0] f_pc1, pred1, f_pc0, pred0;
    logic        hit1, pend1, halt1, hit0, pend0, halt0;
    logic [2:0]  cnt1, cnt0;

    always #5 clk = ~clk;

    y86_fetch_pc_unit #(.ADDR_W(64), .RAS_DEPTH(4), .RESET_PC(64'h100), .RAS_EN(1'b1)) dut (
        .clk(clk), .reset(rst), .f_stall(f_stall), .f_valid(f_valid), .f_icode(f_icode),
        .f_valC(f_valC), .f_valP(f_valP), .m_mispredict(m_mispredict), .m_valA(m_valA),
        .w_ret(w_ret), .w_valM(w_valM), .f_pc(f_pc1), .pred_pc(pred1), .ras_hit(hit1),
        .ret_pending(pend1), .halted(halt1), .ras_count(cnt1));

    y86_fetch_pc_unit #(.ADDR_W(64), .RAS_DEPTH(4), .RESET_PC(64'h100), .RAS_EN(1'b0)) dut0 (
        .clk(clk), .reset(rst), .f_stall(f_stall), .f_valid(f_valid), .f_icode(f_icode),
        .f_valC(f_valC), .f_valP(f_valP), .m_mispredict(m_mispredict), .m_valA(m_valA),
        .w_ret(w_ret), .w_valM(w_valM), .f_pc(f_pc0), .pred_pc(pred0), .ras_hit(hit0),
        .ret_pending(pend0), .halted(halt0), .ras_count(cnt0));

    typedef struct {
        bit          sel;
        string       nm;
        logic [63:0] fpc;
        logic [63:0] pred;
        logic        hit;
        logic        pend;
        logic        halt;
        logic [2:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "f_pc",        e.sel ? f_pc1 : f_pc0, e.fpc);
            chk(e.nm, "pred_pc",     e.sel ? pred1 : pred0, e.pred);
            chk(e.nm, "ras_hit",     64'(e.sel ? hit1 : hit0), 64'(e.hit));
            chk(e.nm, "ret_pending", 64'(e.sel ? pend1 : pend0), 64'(e.pend));
            chk(e.nm, "halted",      64'(e.sel ? halt1 : halt0), 64'(e.halt));
            chk(e.nm, "ras_count",   64'(e.sel ? cnt1 : cnt0), 64'(e.cnt));
        end
    end

    task automatic drv(input logic v, input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                       input logic st, input logic mi, input logic [63:0] ma,
                       input logic wr, input logic [63:0] wm);
        f_valid = v; f_icode = ic; f_valC = vc; f_valP = vp; f_stall = st;
        m_mispredict = mi; m_valA = ma; w_ret = wr; w_valM = wm;
    endtask

    task automatic ins(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
        drv(1'b1, ic, vc, vp, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    endtask

    task automatic idle();
        drv(1'b0, I_NOP, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    endtask

    task automatic ex(input bit sel, input string nm, input logic [63:0] fpc, input logic [63:0] pred,
                      input logic hit, input logic pend, input logic halt, input logic [2:0] cnt);
        exp_t e;
        e.sel = sel; e.nm = nm; e.fpc = fpc; e.pred = pred;
        e.hit = hit; e.pend = pend; e.halt = halt; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] pv;
        rst = 1'b1;
        idle();
        tick();
        ex(1, "reset",  64'h100, 64'h100, 0, 0, 0, 0);
        ex(0, "reset0", 64'h100, 64'h100, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        ins(I_IRMOVQ, 64'h0, 64'h10A);   ex(1, "irmovq", 64'h100, 64'h100, 0, 0, 0, 0); tick();
        ins(I_JXX, 64'h200, 64'h113);    ex(1, "jxx",    64'h10A, 64'h10A, 0, 0, 0, 0); tick();
        drv(1, I_IRMOVQ, 64'h0, 64'h113, 0, 1, 64'h109, 0, 64'h0);
        ex(1, "mispredict", 64'h109, 64'h200, 0, 0, 0, 0); tick();
        ins(I_CALL, 64'h300, 64'h109);   ex(1, "call",    64'h113, 64'h113, 0, 0, 0, 0); tick();
        ins(I_RET, 64'h0, 64'h301);      ex(1, "ret_hit", 64'h300, 64'h300, 1, 0, 0, 1); tick();
        idle();                          ex(1, "after_ret", 64'h109, 64'h109, 0, 0, 0, 0); tick();

        for (int k = 1; k <= 5; k++) begin
            ins(I_CALL, 64'h2000 + 64'(k * 16), 64'h1000 + 64'(k));
            pv = (k == 1) ? 64'h109 : 64'h2000 + 64'((k - 1) * 16);
            ex(1, $sformatf("ovf_call%0d", k), pv, pv, 0, 0, 0, (k == 5) ? 3'd4 : 3'(k - 1));
            tick();
        end
        for (int j = 1; j <= 4; j++) begin
            ins(I_RET, 64'h0, 64'h1FFF);
            pv = (j == 1) ? 64'h2050 : 64'h1000 + 64'(7 - j);
            ex(1, $sformatf("ovf_ret%0d", j), pv, pv, 1, 0, 0, 3'(5 - j));
            tick();
        end
        ins(I_RET, 64'h0, 64'h1003);     ex(1, "ret_empty",   64'h1002, 64'h1002, 0, 0, 0, 0); tick();
        ins(I_IRMOVQ, 64'h0, 64'h5555);  ex(1, "ret_blocked", 64'h1003, 64'h1003, 0, 1, 0, 0); tick();
        drv(1, I_IRMOVQ, 64'h0, 64'h100B, 0, 0, 64'h0, 1, 64'h1001);
        ex(1, "ret_resolve", 64'h1001, 64'h1003, 0, 1, 0, 0); tick();
        idle();                          ex(1, "after_resolve", 64'h100B, 64'h100B, 0, 0, 0, 0); tick();

        ins(I_CALL, 64'h400, 64'h110);   ex(1, "call2", 64'h100B, 64'h100B, 0, 0, 0, 0); tick();
        drv(1, I_RET, 64'h0, 64'h501, 0, 0, 64'h0, 1, 64'h500);
        ex(1, "ras_miss", 64'h500, 64'h400, 0, 0, 0, 1); tick();
        drv(1, I_NOP, 64'h0, 64'h602, 0, 1, 64'h600, 1, 64'h700);
        ex(1, "mis_and_wret", 64'h600, 64'h501, 0, 1, 0, 0); tick();
        idle();                          ex(1, "after_both", 64'h602, 64'h602, 0, 0, 0, 0); tick();

        for (int s = 0; s < 3; s++) begin
            drv(1, I_CALL, 64'h800, 64'h60B, 1, s == 1, 64'h900, 0, 64'h0);
            ex(1, $sformatf("stall%0d", s), (s == 1) ? 64'h900 : 64'h602, 64'h602, 0, 0, 0, 0);
            tick();
        end
        ins(I_CALL, 64'h800, 64'h60B);   ex(1, "unstall_call", 64'h602, 64'h602, 0, 0, 0, 0); tick();
        ins(I_JXX, 64'h40, 64'h809);     ex(1, "jmp40", 64'h800, 64'h800, 0, 0, 0, 1); tick();
        ins(I_HALT, 64'h0, 64'h41);      ex(1, "halt",  64'h40, 64'h40, 0, 0, 0, 1); tick();
        for (int h = 0; h < 3; h++) begin
            ins(I_CALL, 64'h99, 64'h49);
            ex(1, $sformatf("halted_hold%0d", h), 64'h40, 64'h40, 0, 0, 1, 1);
            tick();
        end

        idle();
        #1 rst = 1'b1;
        ex(1, "async_reset",  64'h100, 64'h100, 0, 0, 0, 0);
        ex(0, "async_reset0", 64'h100, 64'h100, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        ins(I_CALL, 64'h300, 64'h105);   ex(0, "en0_call", 64'h100, 64'h100, 0, 0, 0, 0); tick();
        ins(I_RET, 64'h0, 64'h301);
        ex(0, "en0_ret", 64'h300, 64'h300, 0, 0, 0, 1);
        ex(1, "en1_ret", 64'h300, 64'h300, 1, 0, 0, 1); tick();
        for (int b = 0; b < 3; b++) begin
            ins(I_IRMOVQ, 64'h0, 64'h777);
            ex(0, $sformatf("en0_blocked%0d", b), 64'h301, 64'h301, 0, 1, 0, 1);
            tick();
        end
        drv(1, I_IRMOVQ, 64'h0, 64'h10F, 0, 0, 64'h0, 1, 64'h105);
        ex(0, "en0_resolve", 64'h105, 64'h301, 0, 1, 0, 1);
        ex(1, "en1_flush",   64'h105, 64'h777, 0, 0, 0, 0); tick();
        idle();
        ex(0, "en0_after", 64'h10F, 64'h10F, 0, 0, 0, 1);
        ex(1, "en1_after", 64'h10F, 64'h10F, 0, 0, 0, 0); tick();

        ins(4'hD, 64'h0, 64'h120);       ex(1, "invalid_icode",  64'h10F, 64'h10F, 0, 0, 0, 0); tick();
        idle();                          ex(1, "invalid_halted", 64'h10F, 64'h10F, 0, 0, 1, 0); tick();

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
